uart_tx_frame: RTL
==================

# uart_tx_frame

UART transmit framer: accepts one parallel data word, serializes it onto a single line as start bit, data bits LSB first, optional parity bit, and stop bit(s). It is the transmit counterpart of the UART receive path and sits between the system data source and the TX pad. The parity it generates uses the same EVEN/ODD convention the receive-side parity checker expects. CLK is the TX bit clock: one bit per CLK cycle.

## Interface
- Data_Width, 8, width of the parallel data word (≥1)
- CLK  in  1  TX bit clock; all state changes on rising edge
- RST  in  1  asynchronous, active-low reset
- P_DATA  in  Data_Width  parallel word to transmit
- Data_Valid  in  1  request to send P_DATA; sampled only while Busy=0
- Parity_EN  in  1  1 = insert parity bit after data
- Parity_TYP  in  1  0 = EVEN, 1 = ODD
- TX_OUT  out  1  serial line, idle high; registered
- Busy  out  1  high from accept edge until frame's last stop bit completes; registered

## Operation
- States: IDLE, START, DATA, PARITY, STOP.
- IDLE: TX_OUT=1, Busy=0. On an edge with Data_Valid=1: latch P_DATA, Parity_EN, Parity_TYP into internal registers, go to START, TX_OUT<=0, Busy<=1.
- START → DATA: TX_OUT<=latched data[0], bit counter = 0.
- DATA: each edge outputs next bit (data[1]..data[Data_Width-1]); after bit Data_Width-1 has been driven for one cycle: go to PARITY if latched Parity_EN, else STOP.
- PARITY: bit = ^data for EVEN (total ones incl. parity even), ~^data for ODD; driven one cycle, then STOP.
- STOP: TX_OUT=1 for one cycle (two with macro), then IDLE, Busy<=0.
- Data_Valid while Busy=1 is ignored (no queueing); P_DATA/Parity_* changes mid-frame have no effect.
- Parity computed from latched data, never live P_DATA.
- Bit counter width $clog2(Data_Width); must not wrap before final data bit for Data_Width non-power-of-two.

## Timing
- Reset (any time, including mid-frame): TX_OUT=1, Busy=0, state=IDLE, counter=0, latched regs=0, immediately (async); frame aborted, no partial bits resume.
- Accept edge N: TX_OUT=0 and Busy=1 visible after edge N.
- Data bit k driven during cycle after edge N+1+k.
- Frame length (cycles TX_OUT not idle-driven, Busy=1): 1 + Data_Width + Parity_EN + stop count; default 10 or 11.
- Busy falls on the same edge TX_OUT leaves the last stop bit; earliest next accept is that edge+1 (minimum one IDLE cycle between frames).
- Data_Valid held continuously: one frame per (frame length + 1) cycles, each with P_DATA sampled at its accept edge.

## Configuration
- UART_TX_TWO_STOP_EN defined: STOP lasts two cycles (TX_OUT=1 both), frame length +1.
- Undefined: single stop bit. No runtime control either way.

## Structure
- Shared package uart_pkg: state encoding (IDLE/START/DATA/PARITY/STOP), parity type constants EVEN=1'b0/ODD=1'b1, START_BIT=1'b0, STOP_BIT=1'b1 — same constants used by the RX side.
- One natural sub-module: uart_tx_parity_gen (registered latched word + type → parity bit), mirror of the RX checker's arithmetic.
- FSM, counter and output mux stay in uart_tx_frame.

## Test plan
- Reset then idle: no Data_Valid for 20 cycles → TX_OUT=1, Busy=0 throughout.
- P_DATA=8'hA5, Parity_EN=1, EVEN → TX_OUT sequence 0,1,0,1,0,0,1,0,1,0,1 (parity 0), Busy high exactly 11 cycles.
- P_DATA=8'hA5, ODD → parity bit 1; P_DATA=8'h00, Parity_EN=0 → 0×9 then 1, Busy 10 cycles.
- Data_Valid pulsed with 8'h3C mid-frame of 8'hFF → ignored; only 8'hFF frame transmitted; P_DATA changed mid-frame → bits unchanged.
- Data_Valid held high with alternating 8'h55/8'hAA → back-to-back frames separated by exactly one idle-high cycle.
- RST asserted during data bit 4 → TX_OUT=1, Busy=0 same cycle; after release, new frame 8'h81 transmits cleanly. With UART_TX_TWO_STOP_EN: stop phase two cycles, Busy 12 cycles for parity frames.

Source files
------------

// File: rtl/uart_pkg.sv
// ---------------------------------------------------------------------------
// uart_pkg
// Shared UART definitions used by both the transmit framer and the receive
// path, so that both sides agree on framing and parity conventions.
//   uart_state_e : framer states (IDLE, START, DATA, PARITY, STOP)
//   EVEN / ODD   : values of the parity-type select
//   START_BIT    : line level of the start bit
//   STOP_BIT     : line level of the stop bit(s) and of the idle line
// ---------------------------------------------------------------------------
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } uart_state_e;

    localparam logic EVEN      = 1'b0;
    localparam logic ODD       = 1'b1;
    localparam logic START_BIT = 1'b0;
    localparam logic STOP_BIT  = 1'b1;

endpackage

// File: rtl/uart_tx_parity_gen.sv
// ---------------------------------------------------------------------------
// uart_tx_parity_gen
// Parity generator for the TX framer. It works on the word latched at the
// accept edge, never on the live input bus, and uses the same arithmetic as
// the RX checker, so that a matching receiver sees a clean frame.
//   data       in  Data_Width  latched data word
//   parity_typ in  1           EVEN (0) or ODD (1)
//   parity_bit out 1           bit that makes the total number of ones
//                              even (EVEN) or odd (ODD)
// ---------------------------------------------------------------------------
module uart_tx_parity_gen
    import uart_pkg::*;
#(
    parameter int Data_Width = 8
) (
    input  logic [Data_Width-1:0] data,
    input  logic                  parity_typ,
    output logic                  parity_bit
);

    // XOR-reduce gives the EVEN bit; ODD is its complement.
    always_comb begin
        parity_bit = (parity_typ == ODD) ? ~^data : ^data;
    end

endmodule

// File: rtl/uart_tx_frame.sv
// ---------------------------------------------------------------------------
// uart_tx_frame
// UART transmit framer. It accepts a parallel word and serializes it as a
// start bit, then the data bits LSB first, then an optional parity bit, then
// the stop bit(s). One bit is sent per CLK cycle.
//   CLK        in  1           TX bit clock, rising edge
//   RST        in  1           asynchronous, active-low reset
//   P_DATA     in  Data_Width  word to transmit
//   Data_Valid in  1           send request; sampled only while Busy=0
//   Parity_EN  in  1           1 = add a parity bit after the data
//   Parity_TYP in  1           0 = EVEN, 1 = ODD
//   TX_OUT     out 1           serial line, idle high, registered
//   Busy       out 1           frame in progress, registered
// Configuration macro:
//   UART_TX_TWO_STOP_EN  when defined, the stop phase lasts two cycles.
//                        When undefined, a single stop bit is sent.
// ---------------------------------------------------------------------------
module uart_tx_frame
    import uart_pkg::*;
#(
    parameter int Data_Width = 8
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [Data_Width-1:0] P_DATA,
    input  logic                  Data_Valid,
    input  logic                  Parity_EN,
    input  logic                  Parity_TYP,
    output logic                  TX_OUT,
    output logic                  Busy
);

    // The counter must reach Data_Width-1 without wrapping. The counter is
    // also reused to time the two-cycle stop phase, so it is at least 1 bit.
    localparam int CNT_W = (Data_Width > 1) ? $clog2(Data_Width) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(Data_Width - 1);

    uart_state_e           state_q, state_d;
    logic [CNT_W-1:0]      bit_cnt_q, bit_cnt_d;
    logic [CNT_W-1:0]      bit_cnt_inc;
    logic [Data_Width-1:0] data_q, data_d;
    logic                  parity_en_q, parity_en_d;
    logic                  parity_typ_q, parity_typ_d;
    logic                  tx_d, busy_d;
    logic                  parity_bit;

    uart_tx_parity_gen #(
        .Data_Width(Data_Width)
    ) u_parity_gen (
        .data      (data_q),
        .parity_typ(parity_typ_q),
        .parity_bit(parity_bit)
    );

    assign bit_cnt_inc = bit_cnt_q + CNT_W'(1);

    // State, counter, latched request and registered outputs. A reset
    // aborts any frame at once and forces the line back to idle.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q      <= IDLE;
            bit_cnt_q    <= '0;
            data_q       <= '0;
            parity_en_q  <= 1'b0;
            parity_typ_q <= 1'b0;
            TX_OUT       <= STOP_BIT;
            Busy         <= 1'b0;
        end else begin
            state_q      <= state_d;
            bit_cnt_q    <= bit_cnt_d;
            data_q       <= data_d;
            parity_en_q  <= parity_en_d;
            parity_typ_q <= parity_typ_d;
            TX_OUT       <= tx_d;
            Busy         <= busy_d;
        end
    end

    // Next-state and next-output logic. TX_OUT and Busy are computed one
    // cycle early and then registered, so the line has no glitches.
    // Inputs are only looked at in IDLE. This is why requests and input
    // changes during a frame have no effect.
    always_comb begin
        state_d      = state_q;
        bit_cnt_d    = bit_cnt_q;
        data_d       = data_q;
        parity_en_d  = parity_en_q;
        parity_typ_d = parity_typ_q;
        tx_d         = STOP_BIT;
        busy_d       = 1'b1;

        unique case (state_q)
            IDLE: begin
                busy_d = 1'b0;
                if (Data_Valid) begin
                    data_d       = P_DATA;
                    parity_en_d  = Parity_EN;
                    parity_typ_d = Parity_TYP;
                    bit_cnt_d    = '0;
                    state_d      = START;
                    tx_d         = START_BIT;
                    busy_d       = 1'b1;
                end
            end

            START: begin
                state_d   = DATA;
                bit_cnt_d = '0;
                tx_d      = data_q[0];
            end

            DATA: begin
                if (bit_cnt_q == LAST_BIT) begin
                    bit_cnt_d = '0;
                    if (parity_en_q) begin
                        state_d = PARITY;
                        tx_d    = parity_bit;
                    end else begin
                        state_d = STOP;
                        tx_d    = STOP_BIT;
                    end
                end else begin
                    bit_cnt_d = bit_cnt_inc;
                    tx_d      = data_q[bit_cnt_inc];
                end
            end

            PARITY: begin
                state_d   = STOP;
                bit_cnt_d = '0;
                tx_d      = STOP_BIT;
            end

            STOP: begin
`ifdef UART_TX_TWO_STOP_EN
                // The counter is zero on entry. It holds the line high for
                // one more cycle before the frame ends.
                if (bit_cnt_q == '0) begin
                    bit_cnt_d = CNT_W'(1);
                    tx_d      = STOP_BIT;
                end else begin
                    state_d   = IDLE;
                    bit_cnt_d = '0;
                    busy_d    = 1'b0;
                end
`else
                state_d = IDLE;
                busy_d  = 1'b0;
`endif
            end

            default: begin
                state_d   = IDLE;
                bit_cnt_d = '0;
                busy_d    = 1'b0;
            end
        endcase
    end

endmodule
